// File: rtl/gf16_pkg.sv
// gf16_pkg: GF(2^4) constants (P(x) = x^4 + x + 1) and control state shared by the syndrome calculator.
package gf16_pkg;
  localparam logic [4:0] GF_POLY = 5'b10011;
  localparam logic [3:0] ALPHA_POW [15] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
    4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
  };
  typedef enum logic {ACCUM, HOLD} state_e;
endpackage

// File: rtl/gf16_mul.sv
// gf16_mul: combinational GF(2^4) multiply; carry-less product followed by reduction modulo GF_POLY.
module gf16_mul
  import gf16_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [3:0] o_p
);
  logic [6:0] w_prod;
  always_comb begin
    w_prod = '0;
    for (int i = 0; i < 4; i++)
      if (i_b[i]) w_prod = w_prod ^ (7'(i_a) << i);
    for (int i = 6; i >= 4; i--)
      if (w_prod[i]) w_prod = w_prod ^ (7'(GF_POLY) << (i - 4));
    o_p = w_prod[3:0];
  end
endmodule

// File: rtl/rs_syndrome_calc.sv
// rs_syndrome_calc: streaming Reed-Solomon syndrome calculator, Horner evaluation at alpha^1..alpha^NSYN.
// Define RS_SYN_ERRFLAG_EN to register err_flag (OR of all syndromes); otherwise err_flag is tied low.
module rs_syndrome_calc
  import gf16_pkg::*;
#(
  parameter int NSYN = 4,
  parameter int N    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_sym,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NSYN-1:0] syndrome,
  output logic              err_flag
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e            r_state;
  logic [CW-1:0]     r_cnt;
  logic [4*NSYN-1:0] r_syn;
  logic              r_out_valid;
  logic [4*NSYN-1:0] w_next;
  logic              w_acc;
  logic              w_first;
  logic              w_last;
  logic              w_release;

  assign in_ready  = (r_state == ACCUM) || out_ready;
  assign w_acc     = in_valid && in_ready;
  assign w_first   = r_cnt == '0;
  assign w_last    = r_cnt == CW'(N - 1);
  assign w_release = (r_state == HOLD) && out_ready;

  genvar k;
  for (k = 0; k < NSYN; k++) begin : g_lane
    logic [3:0] w_prod;
    gf16_mul u_mul (
      .i_a(r_syn[4*k +: 4]),
      .i_b(ALPHA_POW[k+1]),
      .o_p(w_prod)
    );
    assign w_next[4*k +: 4] = w_prod ^ in_sym;
  end

  // A release and an accept may share a cycle; the accept then starts the next codeword at count 0.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_cnt       <= '0;
      r_syn       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_release) begin
        r_state     <= ACCUM;
        r_out_valid <= 1'b0;
      end
      if (w_acc) begin
        r_syn <= w_first ? {NSYN{in_sym}} : w_next;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          r_state     <= HOLD;
          r_out_valid <= 1'b1;
        end
      end
    end

`ifdef RS_SYN_ERRFLAG_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_err <= 1'b0;
    else if (w_acc && w_last) r_err <= |w_next;
    else if (w_release) r_err <= 1'b0;
  assign err_flag = r_err;
`else
  assign err_flag = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign syndrome  = r_syn;
endmodule
